// File: rtl/affinex_pkg.sv
// Types and constants shared by the affinex arithmetic units (multiplier and divider).
package affinex_pkg;

  localparam int unsigned HS_W              = 1;
  localparam int unsigned DIV_WIDTH_DEFAULT = 16;

  // start/busy/done handshake signal, identical on every arithmetic unit
  typedef logic [HS_W-1:0] hs_t;

  typedef enum logic {
    IDLE,
    RUN
  } div_state_t;

endpackage

// File: rtl/div.sv
// Sequential signed divider, restoring algorithm, one quotient bit per clock.
// Truncates toward zero; divide-by-zero yields -1 rem dividend, overflow wraps.
module div
  import affinex_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  hs_t              start,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero,
  output hs_t              busy,
  output hs_t              done
);

  localparam int unsigned   CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  div_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             zero_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  hs_t              busy_q;
  hs_t              done_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;
  logic             last;

  // The partial remainder stays below the divisor magnitude (<= 2^(WIDTH-1)),
  // so WIDTH bits hold it and only the shifted trial needs the extra bit.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};
    rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_d   = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
    last    = zero_q || (cnt_q == LAST_CNT);
    if (zero_q) begin
      quo_res = '1;
      rem_res = neg_rem_q ? -dvd_q : dvd_q;
    end else begin
      quo_res = neg_quo_q ? -dvd_d : dvd_d;
      rem_res = neg_rem_q ? -rem_d : rem_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the datapath registers are reset too; they are few and it keeps
  // the state fully deterministic after an aborted division.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= '0;
      done_q      <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (|start) begin
            state_q   <= RUN;
            busy_q    <= '1;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
            dsr_q     <= divisor_i[WIDTH-1] ? -divisor_i : divisor_i;
            neg_rem_q <= dividend_i[WIDTH-1];
            neg_quo_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
            zero_q    <= (divisor_i == '0);
          end
        end
        RUN: begin
          if (last) begin
            state_q     <= IDLE;
            busy_q      <= '0;
            done_q      <= '1;
            quotient_q  <= quo_res;
            remainder_q <= rem_res;
            dbz_q       <= zero_q;
          end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
